io_port_bridge: RTL and testbench
=================================

# io_port_bridge

External-side endpoint of the processor's I/O port interface, the counterpart to the CPU's `In_Port` / `Out_Port` / `interupt` pins. It buffers words from an external producer and presents them on `In_Port`. It captures words the CPU writes on `Out_Port` into a FIFO drained by an external consumer. It raises a one-cycle `interupt` pulse when input data becomes available. It sits between the `Processor` top level and board-level I/O.

## Interface
Parameters:
- `WIDTH`, 16: data word width.
- `DEPTH`, 4: entries per FIFO. Power of two, ≥2.
- `IRQ_EN`, 1: 1 enables `interupt` generation; 0 ties `interupt` low.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `ext_in_data`  in  WIDTH: word from the external producer.
- `ext_in_valid`  in  1: producer has a word.
- `ext_in_ready`  out  1: input FIFO can accept a word.
- `In_Port`  out  WIDTH: value the CPU reads on an IN instruction.
- `in_ack`  in  1: CPU consumed `In_Port` this cycle (IN executed).
- `Out_Port`  in  WIDTH: value the CPU writes.
- `out_wr`  in  1: CPU executed OUT this cycle.
- `ext_out_data`  out  WIDTH: head of the output FIFO.
- `ext_out_valid`  out  1: output FIFO non-empty.
- `ext_out_ready`  in  1: consumer accepts `ext_out_data`.
- `interupt`  out  1: interrupt request pulse to the CPU.
- `out_overflow`  out  1: sticky flag; an OUT word was dropped.

## Operation
- Two independent circular FIFOs, input and output. Each has read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
- Input push occurs when `ext_in_valid && ext_in_ready`.
- `ext_in_ready = !in_full`, purely from the current count. A pop in the same cycle does not open a slot for a push when the FIFO is full.
- Input pop occurs when `in_ack && !in_empty`. `in_ack` while empty is ignored; no state changes.
- `In_Port` shows the input FIFO head while non-empty. While empty it holds the last popped word, which is 0 after reset.
- Push and pop in the same cycle on a non-empty, non-full input FIFO: both occur and the count is unchanged.
- Push and `in_ack` in the same cycle on an empty input FIFO: the push occurs and the pop is ignored. The word becomes visible on `In_Port` the next cycle.
- Output write is attempted when `out_wr`. It is accepted if the output FIFO is not full, or if it is full and `ext_out_ready` pops in the same cycle. In that case the count is unchanged.
- Otherwise the word is dropped and `out_overflow` is set. `out_overflow` is cleared only by `reset`.
- Output pop occurs when `ext_out_valid && ext_out_ready`.
- `ext_out_valid = !out_empty`. `ext_out_data` is the head entry, driven combinationally from storage.
- Interrupt FSM states:
  - IDLE → PULSE when `IRQ_EN` and the input count goes from 0 to nonzero at an edge.
  - PULSE → ARMED unconditionally after one cycle.
  - ARMED → IDLE when the input count returns to 0.
- `interupt` is 1 only in PULSE. At most one pulse is issued per empty→non-empty episode.
- Reset mid-operation: both FIFOs are emptied (pointers and counts cleared, stored data discarded). The FSM goes to IDLE and `out_overflow` clears. A pulse in progress is cut off at that edge.

## Timing
- Reset values: `ext_in_ready`=1, `In_Port`=0, `ext_out_valid`=0, `interupt`=0, `out_overflow`=0. `ext_out_data` is don't-care while `ext_out_valid`=0.
- Input latency: a word pushed at edge N appears on `In_Port` after edge N when it is the new head. No added delay.
- Interrupt latency: a first push at edge N gives `interupt`=1 for the cycle between edges N+1 and N+2, exactly one clock wide.
- Output latency: an OUT word written at edge N gives `ext_out_valid`=1 after edge N when the FIFO was empty.
- All flags and counts update only on the rising edge of `clk`. There are no combinational paths from `in_ack` or `out_wr` to any output.

## Test plan
- Reset, then push 0x0005 → `ext_in_ready`=1; `In_Port`=0x0005 the next cycle; `interupt` high for exactly one cycle one edge later. Then `in_ack` → `In_Port` holds 0x0005 and there is no second pulse.
- Push 0x0019, 0xFFFF, 0xF320, 0x0001 without ack → `ext_in_ready`=0. A fifth push with `in_ack` in the same cycle is not accepted. Four acks then read back 0x0019, 0xFFFF, 0xF320, 0x0001 in order, wrapping the pointers.
- With the input FIFO empty, assert `in_ack` and push 0x1234 in the same cycle → `In_Port`=0x1234 and the count is 1.
- Five `out_wr` of 0xA000..0xA004 with `ext_out_ready`=0 → 0xA004 is dropped and `out_overflow`=1. Drain → 0xA000..0xA003 in order, then `ext_out_valid`=0.
- Output FIFO full, `out_wr` 0xBEEF with `ext_out_ready`=1 → 0xBEEF is accepted, `out_overflow` is unchanged, and the count stays 4.
- Two items in each FIFO and `interupt` high, then assert `reset` for one cycle → all reset values restored and `interupt`=0 at the next edge. A later push produces a fresh pulse. With `IRQ_EN`=0, `interupt` never asserts.

Source files
------------

// File: rtl/io_port_bridge.sv
// io_port_bridge: external-side endpoint of the CPU I/O port.
// Input FIFO feeds In_Port, output FIFO captures Out_Port writes, and a
// small FSM raises a one-cycle interupt pulse when input data arrives.
module io_port_bridge #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned IRQ_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  // external producer -> input FIFO
  input  logic [WIDTH-1:0] ext_in_data,
  input  logic             ext_in_valid,
  output logic             ext_in_ready,
  // CPU side
  output logic [WIDTH-1:0] In_Port,
  input  logic             in_ack,
  input  logic [WIDTH-1:0] Out_Port,
  input  logic             out_wr,
  // output FIFO -> external consumer
  output logic [WIDTH-1:0] ext_out_data,
  output logic             ext_out_valid,
  input  logic             ext_out_ready,
  // status
  output logic             interupt,
  output logic             out_overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StArmed
  } irq_state_e;

  // ---------------------------------------------------------------------------
  // Input FIFO state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_in_mem [DEPTH];
  logic [AW-1:0]    r_in_wptr;
  logic [AW-1:0]    r_in_rptr;
  logic [CW-1:0]    r_in_cnt;
  logic [WIDTH-1:0] r_in_last;

  logic             w_in_full;
  logic             w_in_empty;
  logic             w_in_push;
  logic             w_in_pop;
  logic [CW-1:0]    w_in_cnt_next;

  // ---------------------------------------------------------------------------
  // Output FIFO state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_out_mem [DEPTH];
  logic [AW-1:0]    r_out_wptr;
  logic [AW-1:0]    r_out_rptr;
  logic [CW-1:0]    r_out_cnt;
  logic             r_out_overflow;

  logic             w_out_full;
  logic             w_out_empty;
  logic             w_out_push;
  logic             w_out_pop;
  logic             w_out_drop;
  logic [CW-1:0]    w_out_cnt_next;

  // ---------------------------------------------------------------------------
  // Interrupt FSM state
  // ---------------------------------------------------------------------------
  irq_state_e r_irq_state;
  irq_state_e w_irq_state_next;
  logic       w_irq;

  // Input FIFO handshake decode; ready depends only on the registered count.
  always_comb begin
    w_in_full  = (r_in_cnt == FullCnt);
    w_in_empty = (r_in_cnt == '0);
    w_in_push  = ext_in_valid && !w_in_full;
    w_in_pop   = in_ack && !w_in_empty;
    w_in_cnt_next = r_in_cnt;
    unique case ({w_in_push, w_in_pop})
      2'b10:   w_in_cnt_next = r_in_cnt + CntOne;
      2'b01:   w_in_cnt_next = r_in_cnt - CntOne;
      default: w_in_cnt_next = r_in_cnt;
    endcase
  end

  // Input FIFO storage, pointers, count and the last-popped holding word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_in_mem[i] <= '0;
      end
      r_in_wptr <= '0;
      r_in_rptr <= '0;
      r_in_cnt  <= '0;
      r_in_last <= '0;
    end else begin
      if (w_in_push) begin
        r_in_mem[r_in_wptr] <= ext_in_data;
        r_in_wptr           <= r_in_wptr + PtrOne;
      end
      if (w_in_pop) begin
        r_in_last <= r_in_mem[r_in_rptr];
        r_in_rptr <= r_in_rptr + PtrOne;
      end
      r_in_cnt <= w_in_cnt_next;
    end
  end

  // Output FIFO decode; a full FIFO still accepts a write when the head pops.
  always_comb begin
    w_out_full  = (r_out_cnt == FullCnt);
    w_out_empty = (r_out_cnt == '0);
    w_out_pop   = !w_out_empty && ext_out_ready;
    w_out_push  = out_wr && (!w_out_full || w_out_pop);
    w_out_drop  = out_wr && !w_out_push;
    w_out_cnt_next = r_out_cnt;
    unique case ({w_out_push, w_out_pop})
      2'b10:   w_out_cnt_next = r_out_cnt + CntOne;
      2'b01:   w_out_cnt_next = r_out_cnt - CntOne;
      default: w_out_cnt_next = r_out_cnt;
    endcase
  end

  // Output FIFO storage, pointers, count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_out_mem[i] <= '0;
      end
      r_out_wptr     <= '0;
      r_out_rptr     <= '0;
      r_out_cnt      <= '0;
      r_out_overflow <= 1'b0;
    end else begin
      if (w_out_push) begin
        r_out_mem[r_out_wptr] <= Out_Port;
        r_out_wptr            <= r_out_wptr + PtrOne;
      end
      if (w_out_pop) begin
        r_out_rptr <= r_out_rptr + PtrOne;
      end
      r_out_cnt <= w_out_cnt_next;
      if (w_out_drop) begin
        r_out_overflow <= 1'b1;
      end
    end
  end

  // Interrupt state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_state <= StIdle;
    end else begin
      r_irq_state <= w_irq_state_next;
    end
  end

  // Interrupt next-state: IDLE is only entered with an empty input FIFO, so
  // a nonzero count seen in IDLE marks the start of a new non-empty episode.
  // Using the registered count places the pulse one cycle after the push.
  always_comb begin
    w_irq_state_next = r_irq_state;
    w_irq            = 1'b0;
    unique case (r_irq_state)
      StIdle: begin
        if ((IRQ_EN != 0) && (r_in_cnt != '0)) begin
          w_irq_state_next = StPulse;
        end
      end
      StPulse: begin
        w_irq            = 1'b1;
        w_irq_state_next = StArmed;
      end
      StArmed: begin
        if (r_in_cnt == '0) begin
          w_irq_state_next = StIdle;
        end
      end
      default: begin
        w_irq_state_next = StIdle;
      end
    endcase
  end

  // Output drive: everything derives from registered state only.
  always_comb begin
    ext_in_ready  = !w_in_full;
    In_Port       = w_in_empty ? r_in_last : r_in_mem[r_in_rptr];
    ext_out_valid = !w_out_empty;
    ext_out_data  = r_out_mem[r_out_rptr];
    interupt      = (IRQ_EN != 0) ? w_irq : 1'b0;
    out_overflow  = r_out_overflow;
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed self-checking bench for io_port_bridge. A second instance with
// IRQ_EN=0 shares the stimulus and must never raise interupt.
module tb_io_port_bridge;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_valid;
  logic             ext_in_ready;
  logic [WIDTH-1:0] In_Port;
  logic             in_ack;
  logic [WIDTH-1:0] Out_Port;
  logic             out_wr;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_valid;
  logic             ext_out_ready;
  logic             interupt;
  logic             out_overflow;

  logic             n_ext_in_ready;
  logic [WIDTH-1:0] n_in_port;
  logic [WIDTH-1:0] n_ext_out_data;
  logic             n_ext_out_valid;
  logic             n_interupt;
  logic             n_out_overflow;

  int n_tests;
  int n_fail;
  int n_irq_off;

  io_port_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IRQ_EN(1)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .In_Port       (In_Port),
    .in_ack        (in_ack),
    .Out_Port      (Out_Port),
    .out_wr        (out_wr),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .interupt      (interupt),
    .out_overflow  (out_overflow)
  );

  io_port_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IRQ_EN(0)) u_dut_noirq (
    .clk           (clk),
    .reset         (reset),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (n_ext_in_ready),
    .In_Port       (n_in_port),
    .in_ack        (in_ack),
    .Out_Port      (Out_Port),
    .out_wr        (out_wr),
    .ext_out_data  (n_ext_out_data),
    .ext_out_valid (n_ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .interupt      (n_interupt),
    .out_overflow  (n_out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count any interrupt from the IRQ-disabled instance.
  always @(negedge clk) begin
    if (n_interupt === 1'b1) n_irq_off <= n_irq_off + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [WIDTH-1:0] d);
    ext_in_data  = d;
    ext_in_valid = 1'b1;
    tick();
    ext_in_valid = 1'b0;
  endtask

  task automatic ack_in();
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
  endtask

  task automatic write_out(input logic [WIDTH-1:0] d);
    Out_Port = d;
    out_wr   = 1'b1;
    tick();
    out_wr   = 1'b0;
  endtask

  logic [WIDTH-1:0] burst [4];
  logic [WIDTH-1:0] drain_exp [4];

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    n_irq_off     = 0;
    reset         = 1'b1;
    ext_in_data   = '0;
    ext_in_valid  = 1'b0;
    in_ack        = 1'b0;
    Out_Port      = '0;
    out_wr        = 1'b0;
    ext_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check_eq("rst_in_ready", 32'(ext_in_ready), 32'd1);
    check_eq("rst_in_port", 32'(In_Port), 32'h0);
    check_eq("rst_out_valid", 32'(ext_out_valid), 32'd0);
    check_eq("rst_irq", 32'(interupt), 32'd0);
    check_eq("rst_ovf", 32'(out_overflow), 32'd0);

    // Single push, interrupt timing, ack holds last word
    push_in(16'h0005);
    check_eq("t1_in_port", 32'(In_Port), 32'h0005);
    check_eq("t1_irq_n", 32'(interupt), 32'd0);
    tick();
    check_eq("t1_irq_n1", 32'(interupt), 32'd1);
    tick();
    check_eq("t1_irq_n2", 32'(interupt), 32'd0);
    ack_in();
    check_eq("t1_hold", 32'(In_Port), 32'h0005);
    check_eq("t1_ready", 32'(ext_in_ready), 32'd1);
    tick();
    check_eq("t1_no_2nd_irq_a", 32'(interupt), 32'd0);
    tick();
    check_eq("t1_no_2nd_irq_b", 32'(interupt), 32'd0);

    // Fill to full, rejected push during ack, ordered readback with wrap
    burst[0] = 16'h0019;
    burst[1] = 16'hFFFF;
    burst[2] = 16'hF320;
    burst[3] = 16'h0001;
    for (int i = 0; i < 4; i++) push_in(burst[i]);
    check_eq("t2_full_ready", 32'(ext_in_ready), 32'd0);
    check_eq("t2_head0", 32'(In_Port), 32'h0019);
    ext_in_data  = 16'hDEAD;
    ext_in_valid = 1'b1;
    in_ack       = 1'b1;
    tick();
    ext_in_valid = 1'b0;
    in_ack       = 1'b0;
    check_eq("t2_after_pop_ready", 32'(ext_in_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      check_eq($sformatf("t2_head%0d", i), 32'(In_Port), 32'(burst[i]));
      ack_in();
    end
    check_eq("t2_hold_last", 32'(In_Port), 32'h0001);
    check_eq("t2_empty_ready", 32'(ext_in_ready), 32'd1);

    // Push and ack on an empty FIFO: push wins, count is 1
    ext_in_data  = 16'h1234;
    ext_in_valid = 1'b1;
    in_ack       = 1'b1;
    tick();
    ext_in_valid = 1'b0;
    in_ack       = 1'b0;
    check_eq("t3_in_port", 32'(In_Port), 32'h1234);
    push_in(16'h0001);
    push_in(16'h0002);
    check_eq("t3_not_full", 32'(ext_in_ready), 32'd1);
    push_in(16'h0003);
    check_eq("t3_full", 32'(ext_in_ready), 32'd0);
    drain_exp[0] = 16'h1234;
    drain_exp[1] = 16'h0001;
    drain_exp[2] = 16'h0002;
    drain_exp[3] = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_drain%0d", i), 32'(In_Port), 32'(drain_exp[i]));
      ack_in();
    end

    // Output FIFO: fill, full write with concurrent pop, overflow, drain
    for (int i = 0; i < 4; i++) write_out(16'hA000 + 16'(i));
    check_eq("t4_valid", 32'(ext_out_valid), 32'd1);
    check_eq("t4_head", 32'(ext_out_data), 32'hA000);
    check_eq("t4_no_ovf", 32'(out_overflow), 32'd0);
    Out_Port      = 16'hBEEF;
    out_wr        = 1'b1;
    ext_out_ready = 1'b1;
    tick();
    out_wr        = 1'b0;
    ext_out_ready = 1'b0;
    check_eq("t5_beef_ovf", 32'(out_overflow), 32'd0);
    check_eq("t5_head", 32'(ext_out_data), 32'hA001);
    write_out(16'hA004);
    check_eq("t4_ovf_set", 32'(out_overflow), 32'd1);
    drain_exp[0] = 16'hA001;
    drain_exp[1] = 16'hA002;
    drain_exp[2] = 16'hA003;
    drain_exp[3] = 16'hBEEF;
    ext_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t4_drain_valid%0d", i), 32'(ext_out_valid), 32'd1);
      check_eq($sformatf("t4_drain%0d", i), 32'(ext_out_data), 32'(drain_exp[i]));
      tick();
    end
    ext_out_ready = 1'b0;
    check_eq("t4_empty", 32'(ext_out_valid), 32'd0);
    check_eq("t4_ovf_sticky", 32'(out_overflow), 32'd1);

    // Mid-operation reset
    write_out(16'h0033);
    write_out(16'h0044);
    check_eq("t6_out_valid", 32'(ext_out_valid), 32'd1);
    push_in(16'h0011);
    push_in(16'h0022);
    check_eq("t6_irq_pre", 32'(interupt), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_irq", 32'(interupt), 32'd0);
    check_eq("t6_in_ready", 32'(ext_in_ready), 32'd1);
    check_eq("t6_in_port", 32'(In_Port), 32'h0);
    check_eq("t6_out_valid0", 32'(ext_out_valid), 32'd0);
    check_eq("t6_ovf", 32'(out_overflow), 32'd0);
    tick();
    check_eq("t6_irq_quiet", 32'(interupt), 32'd0);
    push_in(16'h0055);
    check_eq("t6_new_head", 32'(In_Port), 32'h0055);
    check_eq("t6_irq_n", 32'(interupt), 32'd0);
    tick();
    check_eq("t6_fresh_irq", 32'(interupt), 32'd1);
    tick();
    check_eq("t6_fresh_irq_end", 32'(interupt), 32'd0);
    tick();

    // IRQ-disabled instance never pulsed, but did track data
    check_eq("irq_en0_count", 32'(n_irq_off), 32'd0);
    check_eq("irq_en0_in_port", 32'(n_in_port), 32'h0055);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
